// File: rtl/submod_dp_seq.sv
// Word-serial double-word modular subtractor: res = (inA - inB) mod {BLS381_CHAR, W'b0}.
// Define SUBMOD_NEG_EN to add the neg port (minuend forced to zero, giving -inB mod M).
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef BLS381_CHAR
`define BLS381_CHAR 32'h1A0111EA
`endif

module submod_dp_seq (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [2*`WORD_SIZE-1:0]   inA,
   input  logic [2*`WORD_SIZE-1:0]   inB,
`ifdef SUBMOD_NEG_EN
   input  logic                      neg,
`endif
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [2*`WORD_SIZE-1:0]   res
);

   localparam int          W    = `WORD_SIZE;
   localparam logic [W-1:0] CHAR = `BLS381_CHAR;

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

   state_t          state_q, state_d;
   logic [2*W-1:0]  a_q, a_d;
   logic [2*W-1:0]  b_q, b_d;
   logic            bl_q, bl_d;
   logic [W-1:0]    res_lo_q, res_lo_d;
   logic [W-1:0]    res_hi_q, res_hi_d;

   logic [W:0]      lo_diff;
   logic [W:0]      hi_diff;
   logic [W-1:0]    hi_alt;
   logic [2*W-1:0]  a_in;

`ifdef SUBMOD_NEG_EN
   assign a_in = neg ? '0 : inA;
`else
   assign a_in = inA;
`endif

   // Top bit of each (W+1)-bit difference is the borrow out of that word.
   assign lo_diff = {1'b0, a_q[W-1:0]} - {1'b0, b_q[W-1:0]};
   assign hi_diff = {1'b0, a_q[2*W-1:W]} - {1'b0, b_q[2*W-1:W]} - {{W{1'b0}}, bl_q};
   assign hi_alt  = hi_diff[W-1:0] + CHAR;

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      bl_d     = bl_q;
      res_lo_d = res_lo_q;
      res_hi_d = res_hi_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a_in;
               b_d     = inB;
               state_d = LO;
            end
         end
         LO: begin
            res_lo_d = lo_diff[W-1:0];
            bl_d     = lo_diff[W];
            state_d  = HI;
         end
         HI: begin
            // M has a zero low word, so only the high word needs the wrap correction.
            res_hi_d = hi_diff[W] ? hi_alt : hi_diff[W-1:0];
            state_d  = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         bl_q     <= 1'b0;
         res_lo_q <= '0;
         res_hi_q <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         bl_q     <= bl_d;
         res_lo_q <= res_lo_d;
         res_hi_q <= res_hi_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign res       = {res_hi_q, res_lo_q};

endmodule
